// File: rtl/ysyx_22050598_reg_scoreboard.sv
// Register-file scoreboard between decode/register-read and writeback.
// Tracks outstanding writes per architectural register (x1..x31) and
// holds off issue on read-after-write and pending-write-counter overflow.
//
// Ports:
//   clk, rst         : clock (rising edge), synchronous active-high reset
//   id_valid         : decode presents an instruction
//   id_ready         : instruction may issue (issue = id_valid && id_ready)
//   ren              : instruction reads raddr1/raddr2
//   raddr1, raddr2   : source registers
//   rd_wen, rd_addr  : instruction writes rd_addr
//   wb_valid, wb_addr: a writeback completes this cycle
//   flush            : drop all in-flight writes
//   busy             : registered OR of all pending counters
//   wb_err           : sticky, writeback hit a register with nothing pending
//   stall_cnt        : saturating count of id_valid && !id_ready cycles
module ysyx_22050598_reg_scoreboard #(
  parameter int NR_REGS = 32,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              ren,
  input  logic [4:0]        raddr1,
  input  logic [4:0]        raddr2,
  input  logic              rd_wen,
  input  logic [4:0]        rd_addr,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic              flush,
  output logic              busy,
  output logic              wb_err,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NR_REGS];
  logic [CNT_W-1:0] cnt_nxt [NR_REGS];
  logic [CNT_W-1:0] eff     [NR_REGS];
  logic [NR_REGS-1:0] wb_hit;

  logic raw_hazard;
  logic waw_hazard;
  logic fire;
  logic inc;
  logic any_pending;
  logic wb_orphan;

  // Writeback bypass: a write retiring this cycle no longer blocks readers
  // or the overflow check. x0 is always seen as count 0.
  always_comb begin
    for (int unsigned r = 0; r < NR_REGS; r++) begin
      wb_hit[r] = 1'b0;
      eff[r]    = '0;
      if (r != 0) begin
        wb_hit[r] = wb_valid && (32'(wb_addr) == r) && (cnt[r] != '0);
        eff[r]    = cnt[r] - CNT_W'(wb_hit[r]);
      end
    end
  end

  always_comb begin
    raw_hazard = ren && ((eff[raddr1] != '0) || (eff[raddr2] != '0));
    waw_hazard = rd_wen && (rd_addr != 5'd0) && (eff[rd_addr] == CNT_MAX);
    id_ready   = !flush && !raw_hazard && !waw_hazard;
    fire       = id_valid && id_ready;
    wb_orphan  = wb_valid && (wb_addr != 5'd0) && (cnt[wb_addr] == '0);
  end

  // Simultaneous issue and retirement on the same register cancel out.
  always_comb begin
    any_pending = 1'b0;
    inc         = 1'b0;
    for (int unsigned r = 0; r < NR_REGS; r++) begin
      cnt_nxt[r] = '0;
      inc        = 1'b0;
      if (r != 0 && !flush) begin
        inc = fire && rd_wen && (32'(rd_addr) == r);
        case ({inc, wb_hit[r]})
          2'b10:   cnt_nxt[r] = cnt[r] + 1'b1;
          2'b01:   cnt_nxt[r] = cnt[r] - 1'b1;
          default: cnt_nxt[r] = cnt[r];
        endcase
      end
      any_pending = any_pending | (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NR_REGS; r++) begin
        cnt[r] <= '0;
      end
      busy      <= 1'b0;
      wb_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NR_REGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      busy <= any_pending;
      if (wb_orphan) begin
        wb_err <= 1'b1;
      end
      if (id_valid && !id_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_reg_scoreboard.sv
// Directed bench for ysyx_22050598_reg_scoreboard with a queue scoreboard:
// expectations are pushed as each step is driven and popped as the DUT
// outputs are sampled. A narrow stall counter makes saturation reachable.
module tb_ysyx_22050598_reg_scoreboard;

  localparam int PW      = 6;
  localparam int STL_MAX = (1 << PW) - 1;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic          id_ready;
  logic          ren;
  logic [4:0]    raddr1;
  logic [4:0]    raddr2;
  logic          rd_wen;
  logic [4:0]    rd_addr;
  logic          wb_valid;
  logic [4:0]    wb_addr;
  logic          flush;
  logic          busy;
  logic          wb_err;
  logic [PW-1:0] stall_cnt;

  ysyx_22050598_reg_scoreboard #(
    .NR_REGS(32),
    .CNT_W  (2),
    .PERF_W (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .id_valid (id_valid),
    .id_ready (id_ready),
    .ren      (ren),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rd_wen   (rd_wen),
    .rd_addr  (rd_addr),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .busy     (busy),
    .wb_err   (wb_err),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  // Reference state
  int   mcnt[32];
  int   mstall;
  bit   mwb_err;
  logic obs_rdy;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic int m_eff(input logic [4:0] a);
    int c;
    if (a == 5'd0) return 0;
    c = mcnt[a];
    if (wb_valid && wb_addr == a && c != 0) c = c - 1;
    return c;
  endfunction

  function automatic bit m_ready();
    bit raw;
    bit waw;
    raw = ren && (m_eff(raddr1) != 0 || m_eff(raddr2) != 0);
    waw = rd_wen && rd_addr != 5'd0 && m_eff(rd_addr) == 3;
    return !flush && !raw && !waw;
  endfunction

  task automatic m_update(input bit rdy);
    int  old_wb;
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mstall  = 0;
      mwb_err = 1'b0;
      return;
    end
    if (id_valid && !rdy && mstall != STL_MAX) mstall = mstall + 1;
    old_wb = (wb_addr == 5'd0) ? 0 : mcnt[wb_addr];
    if (wb_valid && wb_addr != 5'd0 && old_wb == 0) mwb_err = 1'b1;
    if (flush) begin
      foreach (mcnt[i]) mcnt[i] = 0;
    end else begin
      if (wb_valid && wb_addr != 5'd0 && old_wb != 0) mcnt[wb_addr] = mcnt[wb_addr] - 1;
      if (id_valid && rdy && rd_wen && rd_addr != 5'd0) mcnt[rd_addr] = mcnt[rd_addr] + 1;
    end
  endtask

  function automatic bit m_busy();
    bit b = 1'b0;
    foreach (mcnt[i]) if (mcnt[i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic step(input bit r, input bit v, input bit rn, input int a1, input int a2,
                      input bit w, input int rd, input bit wv, input int wa, input bit fl);
    bit rdy;
    @(negedge clk);
    rst      = r;
    id_valid = v;
    ren      = rn;
    raddr1   = 5'(a1);
    raddr2   = 5'(a2);
    rd_wen   = w;
    rd_addr  = 5'(rd);
    wb_valid = wv;
    wb_addr  = 5'(wa);
    flush    = fl;
    #1;
    obs_rdy = id_ready;
    rdy     = m_ready();
    if (!r) begin
      push("id_ready", 32'(rdy));
      chk(32'(id_ready));
    end
    @(posedge clk);
    m_update(rdy);
    #1;
    push("busy", 32'(m_busy()));
    chk(32'(busy));
    push("wb_err", 32'(mwb_err));
    chk(32'(wb_err));
    push("stall_cnt", 32'(mstall));
    chk(32'(stall_cnt));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (mcnt[i]) mcnt[i] = 0;
    mstall   = 0;
    mwb_err  = 1'b0;
    rst      = 1'b1;
    id_valid = 1'b0;
    ren      = 1'b0;
    raddr1   = '0;
    raddr2   = '0;
    rd_wen   = 1'b0;
    rd_addr  = '0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    flush    = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Independent writer of x7 issues straight out of reset
    step(0, 1, 1, 5, 6, 1, 7, 0, 0, 0);
    push("first_issue_ready", 32'd1); chk(32'(obs_rdy));
    push("cnt7_after_issue", 32'd1);  chk(32'(dut.cnt[7]));
    push("busy_after_issue", 32'd1);  chk(32'(busy));

    // Reader of x7 stalls until the writeback, which bypasses same cycle
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      push("raw_stall_ready", 32'd0); chk(32'(obs_rdy));
    end
    push("stall_after_raw", 32'd3); chk(32'(stall_cnt));
    step(0, 1, 1, 7, 0, 0, 0, 1, 7, 0);
    push("raw_bypass_ready", 32'd1); chk(32'(obs_rdy));
    push("cnt7_after_wb", 32'd0);    chk(32'(dut.cnt[7]));

    // Fill x3 to the counter limit, then hit the overflow hazard
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    push("cnt3_full", 32'd3); chk(32'(dut.cnt[3]));
    step(0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    push("waw_ovf_ready", 32'd0); chk(32'(obs_rdy));
    step(0, 1, 0, 0, 0, 1, 3, 1, 3, 0);
    push("waw_bypass_ready", 32'd1); chk(32'(obs_rdy));
    push("cnt3_inc_dec", 32'd3);     chk(32'(dut.cnt[3]));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    push("cnt3_drained", 32'd0); chk(32'(dut.cnt[3]));

    // x0 is never tracked
    step(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    push("x0_ready", 32'd1); chk(32'(obs_rdy));
    push("x0_busy", 32'd0);  chk(32'(busy));

    // Orphan writebacks: x0 is ignored, x9 sets the sticky flag
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    push("wb_err_x0", 32'd0); chk(32'(wb_err));
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    push("wb_err_x9", 32'd1); chk(32'(wb_err));
    push("cnt9_untouched", 32'd0); chk(32'(dut.cnt[9]));
    idle();
    push("wb_err_sticky", 32'd1); chk(32'(wb_err));

    // Flush beats a concurrent issue and writeback
    step(0, 1, 0, 0, 0, 1, 4, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 8, 0, 0, 0);
    step(0, 1, 1, 4, 0, 1, 5, 1, 4, 1);
    push("flush_ready", 32'd0); chk(32'(obs_rdy));
    push("flush_cnt4", 32'd0);  chk(32'(dut.cnt[4]));
    push("flush_cnt8", 32'd0);  chk(32'(dut.cnt[8]));
    push("flush_cnt5", 32'd0);  chk(32'(dut.cnt[5]));
    push("flush_busy", 32'd0);  chk(32'(busy));

    // Long flush stall drives the perf counter into saturation
    for (int i = 0; i < 70; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    push("stall_saturated", 32'(STL_MAX)); chk(32'(stall_cnt));

    // Back-to-back independent issue
    for (int i = 10; i < 13; i++) begin
      step(0, 1, 1, 1, 2, 1, i, 0, 0, 0);
      push("b2b_ready", 32'd1); chk(32'(obs_rdy));
    end
    push("cnt12_b2b", 32'd1); chk(32'(dut.cnt[12]));

    // Reset in the middle of activity
    step(0, 1, 0, 0, 0, 1, 13, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 13, 0, 0, 0);
    push("rst_busy", 32'd0);   chk(32'(busy));
    push("rst_wb_err", 32'd0); chk(32'(wb_err));
    push("rst_stall", 32'd0);  chk(32'(stall_cnt));
    push("rst_cnt13", 32'd0);  chk(32'(dut.cnt[13]));
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
